// File: rtl/button_pio_event_sequencer.sv
// button_pio_event_sequencer
// Autonomous Avalon-MM master that services a 4-bit button PIO. It programs
// the PIO irq mask, and on each irq it reads and clears the edge-capture
// register and samples the live button levels. It then queues one event word
// {timestamp, level, edge} for software.
// Optional feature: define BUTTON_PIO_EVT_TIMESTAMP_EN to stamp each event
// with a 24-bit free-running cycle count in bits [31:8]. Without the macro
// those bits are 0 and no counter exists.
module button_pio_event_sequencer #(
  parameter logic [3:0] MASK_INIT  = 4'hF,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  output logic [1:0]                  pio_address,
  output logic                        pio_chipselect,
  output logic                        pio_write_n,
  output logic [31:0]                 pio_writedata,
  input  logic [31:0]                 pio_readdata,
  input  logic                        pio_irq,
  input  logic [3:0]                  cfg_mask,
  input  logic                        cfg_mask_wr,
  output logic                        evt_valid,
  output logic [31:0]                 evt_data,
  input  logic                        evt_ready,
  output logic [$clog2(FIFO_DEPTH):0] evt_count,
  output logic                        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    INIT, IDLE, RD_EDGE, CAP_EDGE, CLR_EDGE, RD_DATA, CAP_DATA, PUSH
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_mask_val;
  logic          r_mask_pend;
  logic [3:0]    r_edge_q;
  logic [3:0]    r_lvl_q;
  logic [23:0]   w_ts_q;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_addr;
  logic          w_cs;
  logic          w_wn;
  logic [31:0]   w_wd;
  logic          w_unused;

  // Only the low nibble of a PIO read carries button information.
  assign w_unused = ^pio_readdata[31:4];

  // State register; reset always restarts with the mask write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= INIT;
    else          r_state <= w_next;
  end

  // Next-state and Avalon-MM command decode for the current state.
  always_comb begin
    w_next = r_state;
    w_addr = 2'd0;
    w_cs   = 1'b0;
    w_wn   = 1'b1;
    w_wd   = '0;
    case (r_state)
      INIT: begin
        w_addr = 2'd2;
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_wd   = {28'b0, r_mask_val};
        w_next = IDLE;
      end
      IDLE: begin
        if (r_mask_pend)                                   w_next = INIT;
        else if (pio_irq && (r_count < CW'(FIFO_DEPTH)))   w_next = RD_EDGE;
      end
      RD_EDGE: begin
        w_addr = 2'd3;
        w_cs   = 1'b1;
        w_next = CAP_EDGE;
      end
      // Readdata for the edge register is valid here; an all-zero read is a
      // spurious irq and nothing gets cleared or queued.
      CAP_EDGE: w_next = (pio_readdata[3:0] == 4'd0) ? IDLE : CLR_EDGE;
      CLR_EDGE: begin
        w_addr = 2'd3;
        w_cs   = 1'b1;
        w_wn   = 1'b0;
        w_wd   = {28'b0, r_edge_q};
        w_next = RD_DATA;
      end
      RD_DATA: begin
        w_addr = 2'd0;
        w_cs   = 1'b1;
        w_next = CAP_DATA;
      end
      CAP_DATA: w_next = PUSH;
      PUSH:     w_next = IDLE;
      default:  w_next = INIT;
    endcase
  end

  // While reset is asserted the state already sits in INIT. The bus is held
  // idle during reset so the mask write lands on the first edge after release.
  assign pio_chipselect = w_cs & reset_n;
  assign pio_write_n    = w_wn | ~reset_n;
  assign pio_address    = reset_n ? w_addr : 2'd0;
  assign pio_writedata  = reset_n ? w_wd : 32'd0;
  assign busy           = (r_state != IDLE);

  // Pending mask write: the newest request wins and is consumed when IDLE
  // hands over to INIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask_pend <= 1'b0;
      r_mask_val  <= MASK_INIT;
    end else if (cfg_mask_wr) begin
      r_mask_pend <= 1'b1;
      r_mask_val  <= cfg_mask;
    end else if ((r_state == IDLE) && r_mask_pend) begin
      r_mask_pend <= 1'b0;
    end
  end

  // Capture the edge and level nibbles one cycle after their reads.
  always_ff @(posedge clk) begin
    if (r_state == CAP_EDGE) r_edge_q <= pio_readdata[3:0];
    if (r_state == CAP_DATA) r_lvl_q  <= pio_readdata[3:0];
  end

`ifdef BUTTON_PIO_EVT_TIMESTAMP_EN
  logic [23:0] r_ts_cnt;
  logic [23:0] r_ts_q;

  // Free-running cycle counter, wraps at 2^24.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_ts_cnt <= '0;
    else          r_ts_cnt <= r_ts_cnt + 24'd1;
  end

  // Stamp taken when the edge register is captured.
  always_ff @(posedge clk) begin
    if (r_state == CAP_EDGE) r_ts_q <= r_ts_cnt;
  end

  assign w_ts_q = r_ts_q;
`else
  assign w_ts_q = '0;
`endif

  // ---- event FIFO ----
  // IDLE only starts a pass when there is room, so PUSH never sees a full FIFO.
  assign w_push    = (r_state == PUSH);
  assign evt_valid = (r_count != '0);
  assign w_pop     = evt_valid & evt_ready;
  assign evt_count = r_count;
  assign evt_data  = evt_valid ? r_mem[r_rd_ptr] : 32'd0;

  // Event storage.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_ts_q, r_lvl_q, r_edge_q};
  end

  // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_button_pio_event_sequencer.sv
// Testbench for button_pio_event_sequencer with a behavioural button PIO
// (falling-edge capture, irq mask, registered readdata) and an event scoreboard.
`timescale 1ns/1ps
module tb_button_pio_event_sequencer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic [3:0]  cfg_mask = 4'h0;
  logic        cfg_mask_wr = 1'b0;
  logic        evt_valid;
  logic [31:0] evt_data;
  logic        evt_ready = 1'b0;
  logic [2:0]  evt_count;
  logic        busy;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  button_pio_event_sequencer #(.MASK_INIT(4'hF), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .cfg_mask(cfg_mask), .cfg_mask_wr(cfg_mask_wr),
    .evt_valid(evt_valid), .evt_data(evt_data), .evt_ready(evt_ready),
    .evt_count(evt_count), .busy(busy)
  );

  // Button PIO model, with its own reset so captured edges can outlive a DUT reset.
  logic        pio_rst_n = 1'b0;
  logic [3:0]  btn = 4'hF;
  logic [3:0]  m_prev, m_ec, m_mask;
  logic [31:0] m_rd;

  always @(posedge clk or negedge pio_rst_n) begin
    if (!pio_rst_n) begin
      m_prev <= 4'hF; m_ec <= 4'h0; m_mask <= 4'h0; m_rd <= 32'd0;
    end else begin
      m_prev <= btn;
      for (int i = 0; i < 4; i++) begin
        if (pio_chipselect && !pio_write_n && pio_address == 2'd3 && pio_writedata[i]) m_ec[i] <= 1'b0;
        else if (m_prev[i] && !btn[i]) m_ec[i] <= 1'b1;
      end
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) m_mask <= pio_writedata[3:0];
      case (pio_address)
        2'd0:    m_rd <= {28'b0, btn};
        2'd2:    m_rd <= {28'b0, m_mask};
        2'd3:    m_rd <= {28'b0, m_ec};
        default: m_rd <= 32'd0;
      endcase
    end
  end
  assign pio_readdata = m_rd;
  assign pio_irq      = |(m_ec & m_mask);

  // Cycle counter and bus monitor (write log, access count).
  int unsigned cyc = 0;
  int unsigned n_access = 0;
  logic [1:0]  wl_a[$];
  logic [31:0] wl_d[$];
  int unsigned wl_c[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset_n && pio_chipselect) begin
      n_access <= n_access + 1;
      if (!pio_write_n) begin
        wl_a.push_back(pio_address);
        wl_d.push_back(pio_writedata);
        wl_c.push_back(cyc);
      end
    end
  end

  // Scoreboard of expected {level, edge} bytes.
  logic [7:0] exp_q[$];

  task automatic wait_service(output int unsigned t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (pio_irq && !busy && evt_count < 3'd4) begin ok = 1'b1; t = cyc; end
    end
  endtask

  task automatic wait_count(input logic [2:0] n, output int unsigned t, output bit ok);
    ok = 1'b0; t = 0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (evt_count == n) begin ok = 1'b1; t = cyc; end
    end
  endtask

  task automatic pop_one(output logic [31:0] d, output bit ok);
    ok = 1'b0; d = 32'd0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (evt_valid) begin
        ok = 1'b1; d = evt_data; evt_ready = 1'b1;
        @(posedge clk); #1 evt_ready = 1'b0;
      end
    end
  endtask

  function automatic logic [7:0] next_exp();
    if (exp_q.size() == 0) return 8'hxx;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; pio_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if ({pio_address, pio_chipselect, pio_write_n} !== 4'b0001) begin bad++; $display("FAIL reset_bus got=%b want=0001", {pio_address, pio_chipselect, pio_write_n}); end
    total++; if (pio_writedata !== 32'd0) begin bad++; $display("FAIL reset_wdata got=%h want=0", pio_writedata); end
    total++; if ({evt_valid, evt_data} !== 33'd0) begin bad++; $display("FAIL reset_evt got=%b/%h want=0/0", evt_valid, evt_data); end
    total++; if (evt_count !== 3'd0 || busy !== 1'b1) begin bad++; $display("FAIL reset_cnt_busy got=%0d/%b want=0/1", evt_count, busy); end
    @(posedge clk); #2 reset_n = 1'b1; pio_rst_n = 1'b1;
    #1;
    total++; if ({pio_address, pio_chipselect, pio_write_n} !== 4'b1010 || pio_writedata !== 32'h0000000F) begin bad++; $display("FAIL init_write got=%b/%h want=1010/0000000f", {pio_address, pio_chipselect, pio_write_n}, pio_writedata); end
    @(negedge clk); @(negedge clk);
    total++; if (busy !== 1'b0 || pio_chipselect !== 1'b0) begin bad++; $display("FAIL init_idle got=%b/%b want=0/0", busy, pio_chipselect); end
    total++; if (m_mask !== 4'hF || wl_a.size() != 1) begin bad++; $display("FAIL init_mask got=%h/%0d want=f/1", m_mask, wl_a.size()); end
  endtask

  task automatic test_single_press();
    int unsigned t0, t1; bit ok; logic [31:0] d; logic [7:0] e;
    @(posedge clk); #1 btn = 4'hD; exp_q.push_back(8'hD2);
    wait_service(t0, ok);
    total++; if (!ok) begin bad++; $display("FAIL single_irq got=timeout want=irq"); end
    wait_count(3'd1, t1, ok);
    total++; if (!ok || t1 - t0 !== 32'd7) begin bad++; $display("FAIL single_latency got=%0d want=7", t1 - t0); end
    total++; if (wl_a[$] !== 2'd3 || wl_d[$] !== 32'h2 || wl_c[$] !== t0 + 3) begin bad++; $display("FAIL single_clear got=%0d/%h/%0d want=3/2/%0d", wl_a[$], wl_d[$], wl_c[$], t0 + 3); end
    total++; if (m_ec !== 4'h0 || pio_irq !== 1'b0) begin bad++; $display("FAIL single_ec got=%h/%b want=0/0", m_ec, pio_irq); end
    btn = 4'hF;
    pop_one(d, ok); e = next_exp();
    total++; if (!ok || d[7:0] !== e) begin bad++; $display("FAIL single_evt got=%h want=%h", d[7:0], e); end
  endtask

  task automatic test_two_buttons();
    int unsigned t1; bit ok; logic [31:0] d; logic [7:0] e;
    @(posedge clk); #1 btn = 4'h6; exp_q.push_back(8'h69);
    wait_count(3'd1, t1, ok);
    btn = 4'hF;
    pop_one(d, ok); e = next_exp();
    total++; if (!ok || d[7:0] !== e) begin bad++; $display("FAIL two_evt got=%h want=%h", d[7:0], e); end
    repeat (12) @(negedge clk);
    total++; if (evt_count !== 3'd0) begin bad++; $display("FAIL two_single got=%0d want=0", evt_count); end
  endtask

  task automatic test_pop_empty();
    @(posedge clk); #1 evt_ready = 1'b1;
    repeat (3) @(posedge clk); #1;
    total++; if (evt_count !== 3'd0 || evt_valid !== 1'b0) begin bad++; $display("FAIL pop_empty got=%0d/%b want=0/0", evt_count, evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_fifo_full();
    int unsigned t1, acc0; bit ok; logic [31:0] d; logic [7:0] e;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1 btn = 4'hD; exp_q.push_back(8'hD2);
      wait_count(3'(k + 1), t1, ok);
      btn = 4'hF; repeat (3) @(posedge clk);
    end
    total++; if (evt_count !== 3'd4) begin bad++; $display("FAIL full_count got=%0d want=4", evt_count); end
    acc0 = n_access;
    @(posedge clk); #1 btn = 4'hB;
    repeat (20) @(posedge clk);
    @(negedge clk);
    total++; if (n_access !== acc0 || pio_irq !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL full_hold got=%0d/%b/%b want=%0d/1/0", n_access, pio_irq, busy, acc0); end
    btn = 4'hF; exp_q.push_back(8'hF4);
    pop_one(d, ok); e = next_exp();
    total++; if (!ok || d[7:0] !== e) begin bad++; $display("FAIL full_pop got=%h want=%h", d[7:0], e); end
    wait_count(3'd4, t1, ok);
    total++; if (!ok) begin bad++; $display("FAIL full_resume got=%0d want=4", evt_count); end
    for (int k = 0; k < 4; k++) begin
      pop_one(d, ok); e = next_exp();
      total++; if (!ok || d[7:0] !== e) begin bad++; $display("FAIL full_drain%0d got=%h want=%h", k, d[7:0], e); end
    end
  endtask

  task automatic test_mask_during_service();
    int unsigned t0, t1, acc0; bit ok; logic [31:0] d; logic [7:0] e;
    @(posedge clk); #1 btn = 4'hE; exp_q.push_back(8'hE1);
    wait_service(t0, ok);
    @(negedge clk); cfg_mask = 4'h1; cfg_mask_wr = 1'b1;
    @(negedge clk); cfg_mask_wr = 1'b0;
    wait_count(3'd1, t1, ok);
    total++; if (!ok || t1 - t0 !== 32'd7 || m_mask !== 4'hF) begin bad++; $display("FAIL mask_push got=%0d/%h want=7/f", t1 - t0, m_mask); end
    repeat (3) @(negedge clk);
    total++; if (wl_a[$] !== 2'd2 || wl_d[$] !== 32'h1 || wl_c[$] !== t0 + 8) begin bad++; $display("FAIL mask_write got=%0d/%h/%0d want=2/1/%0d", wl_a[$], wl_d[$], wl_c[$], t0 + 8); end
    btn = 4'hF;
    pop_one(d, ok); e = next_exp();
    total++; if (!ok || d[7:0] !== e) begin bad++; $display("FAIL mask_evt got=%h want=%h", d[7:0], e); end
    acc0 = n_access;
    @(posedge clk); #1 btn = 4'hB;
    repeat (30) @(negedge clk);
    total++; if (evt_count !== 3'd0 || n_access !== acc0 || m_ec !== 4'h4) begin bad++; $display("FAIL mask_block got=%0d/%0d/%h want=0/%0d/4", evt_count, n_access, m_ec, acc0); end
    btn = 4'hF;
    @(negedge clk); cfg_mask = 4'hF; cfg_mask_wr = 1'b1; exp_q.push_back(8'hF4);
    @(negedge clk); cfg_mask_wr = 1'b0;
    pop_one(d, ok); e = next_exp();
    total++; if (!ok || d[7:0] !== e) begin bad++; $display("FAIL mask_restore got=%h want=%h", d[7:0], e); end
  endtask

  task automatic test_reset_mid();
    int unsigned t0; bit ok; logic [31:0] d; logic [7:0] e;
    @(posedge clk); #1 btn = 4'h7; exp_q.push_back(8'h78);
    wait_service(t0, ok);
    @(negedge clk); reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (evt_count !== 3'd0 || busy !== 1'b1 || pio_chipselect !== 1'b0 || m_ec !== 4'h8) begin bad++; $display("FAIL midrst got=%0d/%b/%b/%h want=0/1/0/8", evt_count, busy, pio_chipselect, m_ec); end
    @(posedge clk); #2 reset_n = 1'b1;
    pop_one(d, ok); e = next_exp();
    total++; if (!ok || d[7:0] !== e) begin bad++; $display("FAIL midrst_evt got=%h want=%h", d[7:0], e); end
    btn = 4'hF;
  endtask

  task automatic test_timestamp();
    int unsigned t1; bit ok; logic [31:0] d1, d2; logic [7:0] e; logic [23:0] dts;
    repeat (5) @(posedge clk);
    #1 btn = 4'hD; exp_q.push_back(8'hD2);
    repeat (50) @(posedge clk); #1 btn = 4'hF;
    repeat (50) @(posedge clk); #1 btn = 4'hD; exp_q.push_back(8'hD2);
    wait_count(3'd2, t1, ok);
    total++; if (!ok) begin bad++; $display("FAIL ts_count got=%0d want=2", evt_count); end
    btn = 4'hF;
    pop_one(d1, ok); e = next_exp();
    total++; if (!ok || d1[7:0] !== e) begin bad++; $display("FAIL ts_evt1 got=%h want=%h", d1[7:0], e); end
    pop_one(d2, ok); e = next_exp();
    total++; if (!ok || d2[7:0] !== e) begin bad++; $display("FAIL ts_evt2 got=%h want=%h", d2[7:0], e); end
    dts = d2[31:8] - d1[31:8];
`ifdef BUTTON_PIO_EVT_TIMESTAMP_EN
    total++; if (dts !== 24'd100) begin bad++; $display("FAIL ts_delta got=%0d want=100", dts); end
`else
    total++; if (d1[31:8] !== 24'd0 || d2[31:8] !== 24'd0) begin bad++; $display("FAIL ts_zero got=%h/%h want=0/0 (delta %0d)", d1[31:8], d2[31:8], dts); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_two_buttons();
    test_pop_empty();
    test_fifo_full();
    test_mask_during_service();
    test_reset_mid();
    test_timestamp();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
